// File: rtl/oam_dma.sv
// oam_dma: copies one 256-byte CPU page into PPU OAM after a CPU write to DMA_REG_ADDR.
// Latency: the trigger is followed by 513 halted cycles, or 514 when an ALIGN cycle is needed.
// Backpressure: none; the CPU is stalled through cpu_halt and the DMA takes the bus outright.
//
// Ports:
//   clk, rst                  - single clock; asynchronous active-low reset
//   cpu_addr/d_out/write      - CPU bus request (and DMA trigger source)
//   bus_d_in                  - system bus read data, sampled by the DMA in READ
//   bus_addr/d_out/write      - system bus request, CPU pass-through unless the DMA owns the bus
//   cpu_halt                  - CPU must stall (every state except IDLE)
//   dma_active                - DMA owns the bus (READ/WRITE)
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    input  logic [7:0]  bus_d_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_write,
    output logic        cpu_halt,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        trigger;

    assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            // Free-running; tells HALT whether the first READ would land on the wrong phase.
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        // The CPU keeps the bus in IDLE/HALT/ALIGN, so the trigger write itself goes out.
        bus_addr   = cpu_addr;
        bus_d_out  = cpu_d_out;
        bus_write  = cpu_write;
        cpu_halt   = (state_q != S_IDLE);
        dma_active = (state_q == S_READ) || (state_q == S_WRITE);

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_d_out;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = parity_q ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                bus_addr  = {page_q, idx_q};
                bus_d_out = data_q;
                bus_write = 1'b0;
                data_d    = bus_d_in;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_d_out = data_q;
                bus_write = 1'b1;
                // Stop on FF rather than on wrap, so idx never rolls back to 00.
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
